// File: rtl/uart_rx_pkg.sv
// Shared UART buffer constants and the pointer wrap helper used by the rx and tx buffers.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_W   = 8;
  localparam int unsigned UART_RX_DEPTH = 16;

  // Wraps by explicit compare, so depths that are not powers of two work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port, no reset.
module uart_rx_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: circular FIFO with valid/ready drain, level, sticky overflow and flush.
// Define UART_RX_FIFO_OVERWRITE_EN to overwrite the oldest entry on a push into a full buffer.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = UART_RX_DEPTH,
  parameter int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  input  logic              clr_ovf_i,
  input  logic              flush_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic              pop_c, push_c, ovf_push_c, we_c;
  logic [DATA_W-1:0] mem_rdata;

  // Next-state for pointers, level and flags; flush overrides push and pop.
  always_comb begin
    pop_c      = !empty_q && rd_ready_i;
    push_c     = wr_valid_i && (!full_q || pop_c);
    ovf_push_c = wr_valid_i && full_q && !pop_c;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    we_c       = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_c) begin
        we_c     = 1'b1;
        wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      end
      if (pop_c) rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      if (push_c && !pop_c) level_d = level_q + LVL_W'(1);
      if (pop_c && !push_c) level_d = level_q - LVL_W'(1);
`ifdef UART_RX_FIFO_OVERWRITE_EN
      if (ovf_push_c) begin
        we_c     = 1'b1;
        wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      end
`endif
    end
    if (clr_ovf_i) ovf_d = 1'b0;
    if (ovf_push_c && !flush_i) ovf_d = 1'b1;
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (we_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign rd_valid_o = !empty_q;
  assign rd_data_o  = empty_q ? '0 : mem_rdata;
  assign level_o    = level_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (DEPTH=5): queue model checked every cycle plus directed literal checks.
module tb_uart_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          flush = 1'b0;
  logic          rd_valid, full, empty, overflow;
  logic [DW-1:0] rd_data;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  logic          movf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_data),
    .rd_ready_i (rd_ready),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .level_o    (level),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow),
    .clr_ovf_i  (clr_ovf),
    .flush_i    (flush)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of stored words and an overflow bit.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      automatic bit popped = (mq.size() != 0) && rd_ready;
      automatic bit ovfp   = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (popped) void'(mq.pop_front());
        if (wr_valid) begin
          if (mq.size() < DEPTH) mq.push_back(wr_data);
          else begin
            ovfp = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
            void'(mq.pop_front());
            mq.push_back(wr_data);
`endif
          end
        end
      end
      if (clr_ovf) movf = 1'b0;
      if (ovfp) movf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_level", int'(level), mq.size());
      chk("m_full", int'(full), int'(mq.size() == DEPTH));
      chk("m_empty", int'(empty), int'(mq.size() == 0));
      chk("m_valid", int'(rd_valid), int'(mq.size() != 0));
      chk("m_data", int'(rd_data), (mq.size() != 0) ? int'(mq[0]) : 0);
      chk("m_ovf", int'(overflow), int'(movf));
    end
  end

  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl, input bit co);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    clr_ovf  = co;
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic fill5(input logic [DW-1:0] base);
    for (int i = 1; i <= 5; i++) step(1'b1, base + DW'(i), 1'b0, 1'b0, 1'b0);
  endtask

  logic [DW-1:0] exp_a [5];
  logic [DW-1:0] exp_b [3];

  initial begin
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
`ifdef UART_RX_FIFO_OVERWRITE_EN
    exp_a[0] = 8'hA2; exp_a[1] = 8'hA3; exp_a[2] = 8'hA4; exp_a[3] = 8'hA5; exp_a[4] = 8'hAA;
`else
    exp_a[0] = 8'hA1; exp_a[1] = 8'hA2; exp_a[2] = 8'hA3; exp_a[3] = 8'hA4; exp_a[4] = 8'hA5;
`endif
    #12;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_data", int'(rd_data), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic push then drain
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("t1_level", int'(level), 3);
    chk("t1_head", int'(rd_data), 8'h11);
    for (int i = 0; i < 3; i++) begin
      chk("t1_read", int'(rd_data), int'(exp_b[i]));
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    chk("t1_empty", int'(empty), 1);
    chk("t1_data0", int'(rd_data), 0);

    // Push into full buffer
    fill5(8'hA0);
    chk("t2_full", int'(full), 1);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("t2_level", int'(level), 5);
    chk("t2_ovf", int'(overflow), 1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_read", int'(rd_data), int'(exp_a[i]));
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    chk("t2_ovf_sticky", int'(overflow), 1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t2_clr", int'(overflow), 0);

    // Full with simultaneous push and pop
    fill5(8'hB0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("t3_level", int'(level), 5);
    chk("t3_ovf", int'(overflow), 0);
    chk("t3_head", int'(rd_data), 8'hB2);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t3_last", int'(rd_data), 8'h55);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t3_empty", int'(empty), 1);

    // Streaming across several wraps
    step(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 15; i++) begin
      chk("t4_pre", int'(rd_data), 8'hC0 + i - 1);
      step(1'b1, 8'hC0 + DW'(i), 1'b1, 1'b0, 1'b0);
      chk("t4_level", int'(level), 1);
    end
    chk("t4_tail", int'(rd_data), 8'hCE);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush beats push; then clear overflow
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + DW'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("t5_level", int'(level), 0);
    chk("t5_data", int'(rd_data), 0);
    fill5(8'hE0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("t5_ovf_set", int'(overflow), 1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_ovf_clr", int'(overflow), 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges
    fill5(8'hF0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t6_pre_level", int'(level), 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_level", int'(level), 0);
    chk("t6_empty", int'(empty), 1);
    chk("t6_valid", int'(rd_valid), 0);
    chk("t6_data", int'(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    chk("t6_push_level", int'(level), 1);
    chk("t6_push_data", int'(rd_data), 8'h99);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised receive buffer between the UART receiver and the consumer logic (CPU bus bridge or command parser). Received bytes are pushed on a single-cycle strobe and held in a circular buffer of configurable depth and width. The consumer drains them through a valid/ready read port. The block reports occupancy and a sticky overflow flag, and supports synchronous flush.

## Interface
- `DATA_W`, default 8: width of one stored word.
- `DEPTH`, default 16: number of entries; any value ≥ 2, power of two not required.
- `LVL_W`, default `$clog2(DEPTH+1)`: width of the level output.
- `clk_i`, in, 1: system clock; all logic runs on its rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `wr_valid_i`, in, 1: push strobe, one cycle per received word.
- `wr_data_i`, in, DATA_W: word to push.
- `rd_ready_i`, in, 1: consumer accepts the head word this cycle.
- `rd_valid_o`, out, 1: head word available.
- `rd_data_o`, out, DATA_W: head word; 0 when empty.
- `level_o`, out, LVL_W: number of stored words, 0..DEPTH.
- `full_o`, out, 1: level_o == DEPTH.
- `empty_o`, out, 1: level_o == 0.
- `overflow_o`, out, 1: sticky; set when a push hits a full buffer.
- `clr_ovf_i`, in, 1: clears overflow_o.
- `flush_i`, in, 1: synchronous discard of all contents.

## Operation
- State: `wr_ptr`, `rd_ptr` (each `$clog2(DEPTH)` bits), `level` (LVL_W bits), `overflow`. Storage is DEPTH × DATA_W.
- Pop occurs when `rd_valid_o && rd_ready_i`: `rd_ptr` advances and `level` decrements.
- Push occurs when `wr_valid_i` is high and the buffer is not full, or when it is full and a pop occurs in the same cycle. The word is written at `wr_ptr`, `wr_ptr` advances and `level` increments.
- Simultaneous push and pop: both are performed and `level` is unchanged. This also applies when full.
- Push while full without a pop is governed by the configuration below. In both modes `overflow` is set.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. Wrap is explicit compare, not modulo 2^n.
- `flush_i` has priority over push and pop. Pointers and `level` go to 0. `overflow` is unaffected and storage is not cleared.
- `clr_ovf_i` clears `overflow`. If an overflowing push happens in the same cycle, set wins.
- `rd_data_o` equals `mem[rd_ptr]` when `level != 0`, else 0. It is combinational from registered state.
- Storage is not reset. Only pointers, level and overflow are reset.

## Timing
- Reset values: `rd_valid_o`=0, `rd_data_o`=0, `level_o`=0, `full_o`=0, `empty_o`=1, `overflow_o`=0.
- Push to visibility: a word pushed on edge N appears on `rd_data_o`/`rd_valid_o` after edge N (latency 1 clock, first-word fall-through).
- `level_o`, `full_o`, `empty_o` and `overflow_o` are registered and update on the edge that performs the operation.
- A pop's `rd_data_o` change is visible after the accepting edge.
- Asserting reset mid-operation empties the buffer immediately (asynchronously). The first push after reset deassertion is accepted normally.
- Sustained throughput: one push and one pop per clock.

## Configuration
- `UART_RX_FIFO_OVERWRITE_EN`.
- Defined: a push into a full buffer with no pop overwrites the oldest entry. Both `wr_ptr` and `rd_ptr` advance, `level` stays at DEPTH, and `overflow` is set. This gives ring behaviour for continuous logging.
- Undefined: the incoming word is dropped, pointers and level are unchanged, and `overflow` is set.

## Structure
- Package `uart_rx_pkg`: `UART_DATA_W`=8, default depth constant, and a `ptr_inc(ptr, depth)` wrap function shared with the transmit buffer.
- Sub-module `uart_rx_fifo_mem`: DEPTH × DATA_W register array with one synchronous write port and one asynchronous read port, no reset.
- Pointer, level and overflow control stays in `uart_rx_fifo`.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with `rd_ready_i`=0. Required: `level_o`=3, `rd_data_o`=0x11. Then hold `rd_ready_i`=1 for 3 cycles. Required: reads 0x11, 0x22, 0x33, after which `empty_o`=1 and `rd_data_o`=0.
- DEPTH=5: push 5 words to full, push 0xAA. Without the macro: 0xAA is dropped, `level_o`=5, `overflow_o`=1, head is the first word. With the macro: the head becomes the second word and the tail is 0xAA.
- Full buffer with push 0x55 and pop in the same cycle. Required: `level_o` stays at DEPTH, `overflow_o` stays 0, and 0x55 is read last.
- Continuous push and pop for 3×DEPTH words with DEPTH=5. Required: data order is preserved across wraps and `level_o` stays at 1 throughout.
- Load 4 words, assert `flush_i` together with `wr_valid_i` (0x77). Required: `level_o`=0 and 0x77 is not stored. Then set overflow and assert `clr_ovf_i`. Required: `overflow_o`=0 on the next cycle.
- Assert `rst_i` asynchronously between clock edges with `level_o`=3. Required: outputs take their reset values before the next edge.
